// File: rtl/pre_if_stage_pkg.sv
// rtl/pre_if_stage_pkg.sv - shared constants, types and helpers for the pre-IF fetch stage
package pre_if_stage_pkg;

    localparam int          BR_BUS_LEN      = 34;
    localparam int          PREIF_TO_IF_LEN = 80;
    localparam logic [31:0] RESET_PC_DEF    = 32'h1C000000;
    localparam logic [14:0] ECODE_ADEF_DEF  = 15'h0008;
    localparam logic [1:0]  INST_SIZE_WORD  = 2'b10;
    localparam logic [3:0]  IO_CNT_SAT      = 4'd15;

    typedef enum logic [1:0] {
        REDIR_NONE,
        REDIR_BR,
        REDIR_ERTN,
        REDIR_EX
    } redir_src_e;

    typedef struct packed {
        logic [31:0] nextpc;
        logic        ex;
        logic [14:0] ex_code;
        logic [31:0] ex_vaddr;
    } preif_to_if_t;

    function automatic logic [3:0] io_cnt_next(input logic [3:0] cnt, input logic inc, input logic dec);
        logic [3:0] r;
        r = cnt;
        if (inc && !dec && cnt != IO_CNT_SAT) r = cnt + 4'd1;
        if (dec && !inc && cnt != 4'd0)       r = cnt - 4'd1;
        return r;
    endfunction

endpackage

// File: rtl/pre_if_stage_if.sv
// rtl/pre_if_stage_if.sv - IF hand-off bus and instruction-SRAM request port of the pre-IF stage
interface pre_if_stage_if;

    logic                                        IF_allowin;
    logic                                        preIF_to_IF_valid;
    logic [pre_if_stage_pkg::PREIF_TO_IF_LEN-1:0] preIF_to_IF_BUS;

    logic        inst_sram_req;
    logic        inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;

    modport master (
        input  IF_allowin,
        output preIF_to_IF_valid,
        output preIF_to_IF_BUS,
        output inst_sram_req,
        output inst_sram_wr,
        output inst_sram_size,
        output inst_sram_wstrb,
        output inst_sram_addr,
        output inst_sram_wdata,
        input  inst_sram_addr_ok,
        input  inst_sram_data_ok
    );

    modport slave (
        output IF_allowin,
        input  preIF_to_IF_valid,
        input  preIF_to_IF_BUS,
        input  inst_sram_req,
        input  inst_sram_wr,
        input  inst_sram_size,
        input  inst_sram_wstrb,
        input  inst_sram_addr,
        input  inst_sram_wdata,
        output inst_sram_addr_ok,
        output inst_sram_data_ok
    );

endinterface

// File: rtl/pre_if_redirect_buf.sv
// rtl/pre_if_redirect_buf.sv - redirect priority mux plus one-entry target buffer
module pre_if_redirect_buf
    import pre_if_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_ex_i,
    input  logic        ertn_flush_i,
    input  logic        br_cancel_i,
    input  logic [31:0] ex_entry_i,
    input  logic [31:0] ertn_pc_i,
    input  logic [31:0] br_target_i,
    input  logic        consume_i,
    output logic        live_o,
    output logic [31:0] live_target_o,
    output logic        buf_valid_o,
    output logic [31:0] buf_target_o
);

    redir_src_e  src;
    logic        buf_valid_q;
    logic [31:0] buf_target_q;

    always_comb begin
        src           = REDIR_NONE;
        live_target_o = br_target_i;
        if (wb_ex_i) begin
            src           = REDIR_EX;
            live_target_o = ex_entry_i;
        end else if (ertn_flush_i) begin
            src           = REDIR_ERTN;
            live_target_o = ertn_pc_i;
        end else if (br_cancel_i) begin
            src           = REDIR_BR;
            live_target_o = br_target_i;
        end
    end

    assign live_o = (src != REDIR_NONE);

    // A live redirect never issues in its own cycle, so it is always parked here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_valid_q  <= 1'b0;
            buf_target_q <= 32'd0;
        end else if (live_o) begin
            buf_valid_q  <= 1'b1;
            buf_target_q <= live_target_o;
        end else if (consume_i) begin
            buf_valid_q  <= 1'b0;
        end
    end

    assign buf_valid_o  = buf_valid_q;
    assign buf_target_o = buf_target_q;

endmodule

// File: rtl/pre_if_stage.sv
// rtl/pre_if_stage.sv - pre-IF stage: next-PC selection, inst-SRAM requests, outstanding count
module pre_if_stage
    import pre_if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = RESET_PC_DEF,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [14:0] ECODE_ADEF      = ECODE_ADEF_DEF
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [BR_BUS_LEN-1:0] BR_BUS,
    input  logic                  wb_ex,
    input  logic                  ertn_flush,
    input  logic [31:0]           ex_entry,
    input  logic [31:0]           ertn_pc,
    output logic [3:0]            IO_cnt,
    pre_if_stage_if.master        bus
);

    logic [31:0]  br_target;
    logic         br_taken_unused;
    logic         br_taken_cancel;

    logic         resetn_q;
    logic [31:0]  seq_pc_q;
    logic [3:0]   io_cnt_q;
    logic         ex_hold_q;

    logic         live_redirect;
    logic [31:0]  live_target;
    logic         buf_valid;
    logic [31:0]  buf_target;
    logic [31:0]  nextpc;
    logic         preif_ex;
    logic         req;
    logic         ready_go;
    logic         handoff;
    preif_to_if_t bus_s;

    assign br_target       = BR_BUS[33:2];
    assign br_taken_unused = BR_BUS[1];
    assign br_taken_cancel = BR_BUS[0];

    pre_if_redirect_buf u_redirect_buf (
        .clk          (clk),
        .rst_n        (resetn),
        .wb_ex_i      (wb_ex),
        .ertn_flush_i (ertn_flush),
        .br_cancel_i  (br_taken_cancel),
        .ex_entry_i   (ex_entry),
        .ertn_pc_i    (ertn_pc),
        .br_target_i  (br_target),
        .consume_i    (handoff),
        .live_o       (live_redirect),
        .live_target_o(live_target),
        .buf_valid_o  (buf_valid),
        .buf_target_o (buf_target)
    );

    assign nextpc   = live_redirect ? live_target :
                      buf_valid     ? buf_target  : seq_pc_q + 32'd4;
    assign preif_ex = |nextpc[1:0];

    assign req      = resetn_q & bus.IF_allowin & ~preif_ex & ~live_redirect & ~ex_hold_q
                    & (io_cnt_q < 4'(MAX_OUTSTANDING));
    // A misaligned PC is handed to IF without touching the SRAM; afterwards fetch parks.
    assign ready_go = (req & bus.inst_sram_addr_ok)
                    | (resetn_q & preif_ex & bus.IF_allowin & ~ex_hold_q);
    assign handoff  = ready_go & ~live_redirect;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            resetn_q  <= 1'b0;
            seq_pc_q  <= RESET_PC - 32'd4;
            io_cnt_q  <= 4'd0;
            ex_hold_q <= 1'b0;
        end else begin
            resetn_q <= 1'b1;
            io_cnt_q <= io_cnt_next(io_cnt_q, req & bus.inst_sram_addr_ok, bus.inst_sram_data_ok);
            if (handoff) begin
                seq_pc_q <= nextpc;
            end
            if (live_redirect) begin
                ex_hold_q <= 1'b0;
            end else if (handoff && preif_ex) begin
                ex_hold_q <= 1'b1;
            end
        end
    end

    always_comb begin
        bus_s          = '0;
        bus_s.nextpc   = nextpc;
        bus_s.ex       = preif_ex;
        bus_s.ex_code  = preif_ex ? ECODE_ADEF : 15'd0;
        bus_s.ex_vaddr = preif_ex ? nextpc : 32'd0;
    end

    assign bus.preIF_to_IF_valid = handoff;
    assign bus.preIF_to_IF_BUS   = bus_s;
    assign bus.inst_sram_req     = req;
    assign bus.inst_sram_wr      = 1'b0;
    assign bus.inst_sram_size    = INST_SIZE_WORD;
    assign bus.inst_sram_wstrb   = 4'd0;
    assign bus.inst_sram_addr    = nextpc;
    assign bus.inst_sram_wdata   = 32'd0;
    assign IO_cnt                = io_cnt_q;

endmodule
